// File: rtl/mem_line_arbiter_if.sv
// Cache-side and RAM-side signal bundle for the line-RAM arbiter.
// slave = arbiter view, master = caches/RAM view.
interface mem_line_arbiter_if #(
  parameter int AW = 26,
  parameter int LW = 128
);
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ack;
  logic [LW-1:0] ic_rdata;

  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          dc_ack;
  logic [LW-1:0] dc_rdata;

  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [LW-1:0] mem_wdata;
  logic          mem_we;
  logic [LW-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_rdata,
    output ic_ack, ic_rdata,
    output dc_ack, dc_rdata,
    output mem_raddr, mem_waddr,
    output mem_wdata, mem_we
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_rdata,
    input  ic_ack, ic_rdata,
    input  dc_ack, dc_rdata,
    input  mem_raddr, mem_waddr,
    input  mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin I/D line arbiter in front of the line RAM.
// One access at a time: IDLE -> BUSY (LAT cycles) -> DONE (ack).
module mem_line_arbiter #(
  parameter int LAT = 5,
  parameter int AW  = 26,
  parameter int LW  = 128
) (
  input logic           clk,
  input logic           reset,
  mem_line_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]    state;
  logic          owner;
  logic          is_wr;
  logic          last_grant;
  logic [AW-1:0] addr;
  logic [LW-1:0] wdata;
  logic [3:0]    cnt;
  logic [LW-1:0] ic_line;
  logic [LW-1:0] dc_line;

  logic grant_i;
  logic grant_d;
  logic busy;
  logic last_beat;

  // D wins a tie only when I was served last
  always_comb begin
    grant_d = bus.dc_req &&
              (!bus.ic_req || last_grant == OWN_I);
    grant_i = bus.ic_req && !grant_d;
    busy      = state == S_BUSY;
    last_beat = busy && cnt == '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      owner      <= OWN_I;
      is_wr      <= 1'b0;
      last_grant <= OWN_I;
      addr       <= '0;
      wdata      <= '0;
      cnt        <= '0;
      ic_line    <= '0;
      dc_line    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_i || grant_d) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            is_wr      <= grant_d && bus.dc_we;
            addr       <= grant_d ? bus.dc_addr
                                  : bus.ic_addr;
            wdata      <= (grant_d && bus.dc_we)
                          ? bus.dc_wdata : '0;
            cnt        <= CNT_INIT;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_DONE;
            if (!is_wr) begin
              if (owner == OWN_D)
                dc_line <= bus.mem_rdata;
              else
                ic_line <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM-side outputs park at zero outside BUSY
  assign bus.mem_raddr = busy ? addr  : '0;
  assign bus.mem_waddr = busy ? addr  : '0;
  assign bus.mem_wdata = busy ? wdata : '0;
  assign bus.mem_we    = last_beat && is_wr && !reset;

  assign bus.ic_ack = (state == S_DONE) &&
                      (owner == OWN_I) && !reset;
  assign bus.dc_ack = (state == S_DONE) &&
                      (owner == OWN_D) && !reset;

  assign bus.ic_rdata = ic_line;
  assign bus.dc_rdata = dc_line;

endmodule
